// File: rtl/uart_pkg.sv
// Shared definitions for the UART program loader: FSM state type,
// error cause encodings and the default inter-byte timeout.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN_HI  = 3'd1,
    S_LEN_LO  = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CHECK   = 3'd4
  } loader_state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_CSUM    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam int DEFAULT_TIMEOUT_CYCLES = 20000;

endpackage

// File: rtl/uart_prog_loader_if.sv
// Byte-stream input, program-memory write port and status outputs of the
// loader. The master side is the loader itself.
interface uart_prog_loader_if #(parameter int ADDR_W = 10) ();

  logic              load_en;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        err_code;

  modport master (
    input  load_en, byte_valid, byte_data,
    output mem_we, mem_addr, mem_wdata, busy, done, err, err_code
  );

  modport slave (
    output load_en, byte_valid, byte_data,
    input  mem_we, mem_addr, mem_wdata, busy, done, err, err_code
  );

endinterface

// File: rtl/uart_prog_loader_gap_timer.sv
// Saturating inter-byte gap counter. expired_o flags the cycle in which the
// counter is about to reach TIMEOUT_CYCLES-1, so the registered error pulse
// lands on the same edge as the counter reaching that value.
module gap_timer #(
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_PRELAST = CNT_W'(TIMEOUT_CYCLES - 2);

  logic [CNT_W-1:0] cnt_q;

  // Count enabled cycles, clear on request, hold at the terminal value.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != CNT_LAST)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // A clear in the same cycle wins over expiry.
  assign expired_o = en_i & ~clr_i & (cnt_q == CNT_PRELAST);

endmodule

// File: rtl/uart_prog_loader.sv
// Frame-level loader: parses LEN_HI, LEN_LO, payload, XOR checksum from the
// uart_rx byte stream and writes the payload to program memory at
// sequential addresses starting at 0. Reports done/err with a sticky cause.
module uart_prog_loader
  import uart_pkg::*;
#(
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input logic                clk,
  input logic                rst,
  uart_prog_loader_if.master bus
);

  localparam int MAX_LEN = 1 << ADDR_W;

  loader_state_t     state_q;
  logic              bv_q;
  logic [7:0]        len_hi_q;
  logic [7:0]        acc_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W:0]   rem_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_wdata_q;
  logic              done_q;
  logic              err_q;
  logic [1:0]        err_code_q;

  logic              byte_evt;
  logic [15:0]       len_d;
  logic              timer_en;
  logic              timer_clr;
  logic              timeout;

  // A byte is the rising edge of byte_valid; a held level counts once.
  assign byte_evt  = bus.byte_valid & ~bv_q;
  assign len_d     = {len_hi_q, bus.byte_data};

  // The gap counter only runs inside a frame and restarts on every byte.
  assign timer_en  = (state_q != S_IDLE);
  assign timer_clr = byte_evt | ~timer_en;

  gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (timer_clr),
    .en_i     (timer_en),
    .expired_o(timeout)
  );

  // Frame FSM with registered write port and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bv_q        <= 1'b0;
      len_hi_q    <= '0;
      acc_q       <= '0;
      ptr_q       <= '0;
      rem_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      bv_q     <= bus.byte_valid;
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;

      if (state_q == S_IDLE) begin
        if (bus.load_en && byte_evt) begin
          len_hi_q   <= bus.byte_data;
          err_code_q <= ERR_NONE;
          acc_q      <= '0;
          state_q    <= S_LEN_LO;
        end
      end else if (!bus.load_en) begin
        // Silent abort: no pulse, cause left as it was, byte dropped.
        state_q <= S_IDLE;
      end else if (byte_evt) begin
        case (state_q)
          S_LEN_LO: begin
            if (int'(len_d) > MAX_LEN) begin
              err_q      <= 1'b1;
              err_code_q <= ERR_LEN;
              state_q    <= S_IDLE;
            end else if (len_d == 16'd0) begin
              state_q <= S_CHECK;
            end else begin
              ptr_q   <= '0;
              rem_q   <= (ADDR_W + 1)'(len_d);
              state_q <= S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= ptr_q;
            mem_wdata_q <= bus.byte_data;
            acc_q       <= acc_q ^ bus.byte_data;
            ptr_q       <= ptr_q + 1'b1;
            rem_q       <= rem_q - 1'b1;
            if (rem_q == (ADDR_W + 1)'(1)) begin
              state_q <= S_CHECK;
            end
          end
          S_CHECK: begin
            if (bus.byte_data == acc_q) begin
              done_q     <= 1'b1;
              err_code_q <= ERR_NONE;
            end else begin
              err_q      <= 1'b1;
              err_code_q <= ERR_CSUM;
            end
            state_q <= S_IDLE;
          end
          // S_LEN_HI is never entered: the high length byte is taken in IDLE.
          default: state_q <= S_IDLE;
        endcase
      end else if (timeout) begin
        err_q      <= 1'b1;
        err_code_q <= ERR_TIMEOUT;
        state_q    <= S_IDLE;
      end
    end
  end

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.err_code  = err_code_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader: fixed frame table, random frames
// against a frame-level reference model, and hand-written corner sequences.
module tb_uart_prog_loader;

  localparam int ADDR_W = 10;
  localparam int TMO    = 40;

  typedef logic [7:0]  bq_t[$];
  typedef logic [17:0] wq_t[$];

  typedef struct {
    string      name;
    logic [63:0] b;     // frame bytes, first byte in the top bits
    int         n;
    int         e_done;
    int         e_err;
    logic [1:0] e_code;
    int         e_nw;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

  uart_prog_loader #(
    .ADDR_W        (ADDR_W),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  done_cnt = 0;
  int  err_cnt = 0;
  int  err_cyc = 0;
  int  last_evt_cyc = 0;
  int  back2back = 0;
  logic we_prev = 1'b0;
  wq_t wq;
  vec_t vecs[7];

  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs away from the active edge.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wq.push_back({bus.mem_addr, bus.mem_wdata});
      if (we_prev) back2back++;
    end
    we_prev = (bus.mem_we === 1'b1);
    if (bus.done === 1'b1) done_cnt++;
    if (bus.err === 1'b1) begin
      err_cnt++;
      err_cyc = cyc;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    @(negedge clk);
    bus.byte_data  = b;
    bus.byte_valid = 1'b1;
    @(negedge clk);
    last_evt_cyc = cyc;
    for (int i = 1; i < hold; i++) @(negedge clk);
    bus.byte_valid = 1'b0;
    for (int i = 0; i < gap; i++) @(negedge clk);
  endtask

  task automatic clear_obs();
    done_cnt = 0;
    err_cnt  = 0;
    wq.delete();
  endtask

  // Reference: parse a complete byte stream with the frame rules.
  function automatic void model(input bq_t s, output int e_done, output int e_err,
                                output logic [1:0] e_code, output wq_t e_wq);
    int n;
    logic [7:0] x;
    e_wq   = {};
    e_done = 0;
    e_err  = 0;
    e_code = 2'b00;
    n = int'({s[0], s[1]});
    if (n > (1 << ADDR_W)) begin
      e_err  = 1;
      e_code = 2'b01;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      e_wq.push_back({10'(i), s[2+i]});
      x = x ^ s[2+i];
    end
    if (s[2+n] == x) e_done = 1;
    else begin
      e_err  = 1;
      e_code = 2'b10;
    end
  endfunction

  task automatic send_frame(input bq_t s, input int maxgap);
    clear_obs();
    foreach (s[i]) send_byte(s[i], 1 + $urandom_range(2), int'($urandom_range(maxgap)));
    repeat (3) @(negedge clk);
  endtask

  task automatic check_frame(input string name, input int e_done, input int e_err,
                             input logic [1:0] e_code, input wq_t e_wq);
    int bad;
    bad = 0;
    chk({name, ".done"}, 32'(done_cnt), 32'(e_done));
    chk({name, ".err"}, 32'(err_cnt), 32'(e_err));
    chk({name, ".err_code"}, 32'(bus.err_code), 32'(e_code));
    chk({name, ".busy"}, 32'(bus.busy), 32'd0);
    chk({name, ".nwrites"}, 32'(wq.size()), 32'(e_wq.size()));
    for (int i = 0; i < wq.size() && i < e_wq.size(); i++)
      if (wq[i] !== e_wq[i]) bad++;
    chk({name, ".wdata"}, 32'(bad), 32'd0);
    $display("frame %s writes=%0d done=%0d err=%0d code=%0b", name, wq.size(), done_cnt,
             err_cnt, bus.err_code);
  endtask

  bq_t s;
  wq_t e_wq;
  int  e_done, e_err, n;
  logic [1:0] e_code;

  initial begin
    vecs[0] = '{name:"n3_ok",      b:64'h0003_A501_FF5B_0000, n:6, e_done:1, e_err:0, e_code:2'b00, e_nw:3};
    vecs[1] = '{name:"n2_badcsum", b:64'h0002_1020_0000_0000, n:5, e_done:0, e_err:1, e_code:2'b10, e_nw:2};
    vecs[2] = '{name:"len_1025",   b:64'h0401_0000_0000_0000, n:2, e_done:0, e_err:1, e_code:2'b01, e_nw:0};
    vecs[3] = '{name:"empty_ok",   b:64'h0000_0000_0000_0000, n:3, e_done:1, e_err:0, e_code:2'b00, e_nw:0};
    vecs[4] = '{name:"empty_bad",  b:64'h0000_0100_0000_0000, n:3, e_done:0, e_err:1, e_code:2'b10, e_nw:0};
    vecs[5] = '{name:"n1_7e",      b:64'h0001_7E7E_0000_0000, n:4, e_done:1, e_err:0, e_code:2'b00, e_nw:1};
    vecs[6] = '{name:"n2_ok",      b:64'h0002_C33C_FF00_0000, n:5, e_done:1, e_err:0, e_code:2'b00, e_nw:2};

    bus.load_en    = 1'b1;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset.mem_we", 32'(bus.mem_we), 32'd0);
    chk("reset.busy", 32'(bus.busy), 32'd0);
    chk("reset.done_err", 32'({bus.done, bus.err}), 32'd0);
    chk("reset.mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("reset.mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("reset.err_code", 32'(bus.err_code), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Fixed frame table.
    foreach (vecs[v]) begin
      s = {};
      for (int i = 0; i < vecs[v].n; i++) s.push_back(vecs[v].b[63-8*i -: 8]);
      e_wq = {};
      for (int i = 0; i < vecs[v].e_nw; i++) e_wq.push_back({10'(i), s[2+i]});
      send_frame(s, 3);
      check_frame(vecs[v].name, vecs[v].e_done, vecs[v].e_err, vecs[v].e_code, e_wq);
    end

    // Random frames against the reference model.
    for (int f = 0; f < 20; f++) begin
      n = ($urandom_range(7) == 0) ? 1025 + int'($urandom_range(3000)) : int'($urandom_range(12));
      s = {8'(n >> 8), 8'(n)};
      if (n <= 1024) begin
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < n; i++) begin
          s.push_back(8'($urandom));
          x = x ^ s[2+i];
        end
        s.push_back(($urandom_range(3) == 0) ? 8'($urandom) : x);
      end
      model(s, e_done, e_err, e_code, e_wq);
      send_frame(s, 5);
      check_frame($sformatf("rand%0d_n%0d", f, n), e_done, e_err, e_code, e_wq);
    end

    // Full-size image: addresses 0..1023.
    s = {8'h04, 8'h00};
    begin
      logic [7:0] x;
      x = 8'h00;
      for (int i = 0; i < 1024; i++) begin
        s.push_back(8'($urandom));
        x = x ^ s[2+i];
      end
      s.push_back(x);
    end
    model(s, e_done, e_err, e_code, e_wq);
    send_frame(s, 0);
    check_frame("n1024_full", e_done, e_err, e_code, e_wq);

    // Inter-byte timeout: err lands TMO-1 edges after the last byte's edge.
    clear_obs();
    send_byte(8'h00, 1, 0);
    send_byte(8'h02, 1, 0);
    send_byte(8'hAB, 1, 0);
    for (int i = 0; i < TMO + 20 && err_cnt == 0; i++) @(negedge clk);
    chk("timeout.err", 32'(err_cnt), 32'd1);
    chk("timeout.latency", 32'(err_cyc - last_evt_cyc), 32'(TMO - 1));
    repeat (2) @(negedge clk);
    e_wq = {{10'd0, 8'hAB}};
    check_frame("timeout", 0, 1, 2'b11, e_wq);

    // byte_valid held high for 5 cycles counts once.
    clear_obs();
    send_byte(8'h00, 1, 0);
    send_byte(8'h01, 1, 0);
    send_byte(8'h3C, 5, 1);
    send_byte(8'h3C, 1, 2);
    e_wq = {{10'd0, 8'h3C}};
    check_frame("held_valid", 1, 0, 2'b00, e_wq);

    // load_en dropped mid-payload, with a byte arriving in the abort cycle.
    clear_obs();
    send_byte(8'h00, 1, 0);
    send_byte(8'h03, 1, 0);
    send_byte(8'h11, 1, 1);
    bus.load_en    = 1'b0;
    bus.byte_data  = 8'h22;
    bus.byte_valid = 1'b1;
    @(negedge clk);
    bus.byte_valid = 1'b0;
    chk("abort.busy", 32'(bus.busy), 32'd0);
    send_byte(8'h00, 1, 2);
    chk("abort.idle_ignored", 32'(bus.busy), 32'd0);
    bus.load_en = 1'b1;
    repeat (2) @(negedge clk);
    e_wq = {{10'd0, 8'h11}};
    check_frame("load_en_abort", 0, 0, 2'b00, e_wq);

    // Reset mid-payload, then a clean frame.
    clear_obs();
    send_byte(8'h00, 1, 0);
    send_byte(8'h03, 1, 0);
    send_byte(8'h11, 1, 0);
    send_byte(8'h22, 1, 0);
    chk("rst_mid.we_before", 32'(bus.mem_we), 32'd1);
    chk("rst_mid.busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid.outputs", 32'({bus.mem_we, bus.busy, bus.done, bus.err, bus.err_code}), 32'd0);
    chk("rst_mid.addr_data", 32'({bus.mem_addr, bus.mem_wdata}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid.no_pulse", 32'(done_cnt + err_cnt), 32'd0);
    s = {8'h00, 8'h01, 8'h7E, 8'h7E};
    e_wq = {{10'd0, 8'h7E}};
    send_frame(s, 2);
    check_frame("after_rst", 1, 0, 2'b00, e_wq);

    chk("no_back_to_back_we", 32'(back2back), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_prog_loader.md
# uart_prog_loader

Frame-level controller behind `uart_rx`. It turns the received byte stream into a length-prefixed, checksummed program image and writes it into program memory at sequential addresses. It also reports completion and errors to the core bring-up logic. It sits between the `uart_rx` instance at top level and the write port of program memory.

## Interface

Parameters:

- `ADDR_W`, 10, program memory address width; maximum payload length is 2^ADDR_W bytes.
- `TIMEOUT_CYCLES`, 20000, maximum clk cycles allowed between bytes inside a frame (20 ms at 1 MHz).

Ports:

- `clk`, input, 1, single system clock.
- `rst`, input, 1, reset; synchronous, active-high.
- `load_en`, input, 1, arms the loader; when low, incoming bytes are ignored.
- `byte_valid`, input, 1, `rx_done_out` from `uart_rx`; its rising edge marks one received byte.
- `byte_data`, input, 8, `data_out` from `uart_rx`; stable when `byte_valid` rises.
- `mem_we`, output, 1, program memory write strobe, one cycle per payload byte.
- `mem_addr`, output, ADDR_W, write address.
- `mem_wdata`, output, 8, write data.
- `busy`, output, 1, high while a frame is in progress (any state except IDLE).
- `done`, output, 1, one-cycle pulse when a frame completes with a good checksum.
- `err`, output, 1, one-cycle pulse on frame error.
- `err_code`, output, 2, last error cause: 00 none, 01 length too large, 10 checksum mismatch, 11 inter-byte timeout. Held until the next frame starts.

## Operation

- Frame format: LEN_HI, LEN_LO (16-bit big-endian length N), then N payload bytes, then one checksum byte equal to the XOR of all payload bytes.
- Byte event: `byte_valid` is registered once. An event is a 0→1 transition between the registered and current values. A level held high counts as one byte.
- FSM states: IDLE, LEN_HI, LEN_LO, PAYLOAD, CHECK.
- IDLE: `load_en` high and a byte event → latch the byte as LEN_HI, clear `err_code`, clear the checksum accumulator, go to LEN_LO. IDLE is the only state where `busy` is 0.
- LEN_LO: on a byte event, form N.
  - N > 2^ADDR_W → `err` pulse, `err_code`=01, go to IDLE.
  - N = 0 → go to CHECK.
  - Otherwise → go to PAYLOAD with address counter = 0 and remaining count = N.
- PAYLOAD: on each byte event, issue a memory write, XOR the byte into the accumulator, increment the address (wraps at 2^ADDR_W only when N = 2^ADDR_W), and decrement the remaining count. When the count reaches 0, go to CHECK.
- CHECK: on a byte event, compare it with the accumulator.
  - Equal → `done` pulse, `err_code`=00.
  - Not equal → `err` pulse, `err_code`=10.
  - In both cases go to IDLE.
  - For N = 0 the expected checksum is 0x00.
- Timeout: a gap counter clears on every byte event and increments every cycle outside IDLE. When it reaches TIMEOUT_CYCLES-1 → `err` pulse, `err_code`=11, go to IDLE.
- Written bytes are not rolled back on any error; the consumer must use `done`.
- `load_en` falling mid-frame → abort to IDLE with no `err` and `err_code` unchanged. Byte events in IDLE while `load_en` is low are discarded.

## Timing

- Reset values: state IDLE; `mem_we`, `done`, `err`, `busy` = 0; `mem_addr` = 0; `mem_wdata` = 0; `err_code` = 00; accumulator and counters = 0.
- A byte event seen in cycle k (`byte_valid` sampled high at edge k, low at edge k-1) gives:
  - `mem_we`/`mem_addr`/`mem_wdata` valid for exactly cycle k+1, all registered.
  - `done`/`err` high for exactly cycle k+1.
  - The state change is visible in cycle k+1.
- Consecutive byte events are at least 2 cycles apart (edge detection), so `mem_we` is never high in two consecutive cycles.
- Byte event and timeout in the same cycle: the byte wins and the counter clears.
- `rst` mid-frame: return to the reset values on the next edge with no `done`/`err` pulse; a partially written image is left as is.
- `load_en` low and a byte event in the same cycle: abort wins and the byte is dropped.
- Counter widths: length 16 bits; remaining count ADDR_W+1 bits; gap counter $clog2(TIMEOUT_CYCLES) bits, saturating.

## Structure

- Shared package `uart_pkg`:
  - state enum `loader_state_t`;
  - `err_code` constants `ERR_NONE`, `ERR_LEN`, `ERR_CSUM`, `ERR_TIMEOUT`;
  - the default `TIMEOUT_CYCLES`.
- One sub-module, `gap_timer`: a saturating cycle counter with clear/enable inputs and an `expired` output, parameterised by TIMEOUT_CYCLES.
- Everything else lives in the single FSM module.

## Test plan

- N=3, payload A5 01 FF, checksum 5B → writes A5@0, 01@1, FF@2; `done` pulse 1 cycle after the checksum byte; `err_code`=00.
- N=2, payload 10 20, checksum 00 → two writes, then `err` pulse with `err_code`=10; `busy` falls the same cycle.
- ADDR_W=10, header 04 01 (N=1025) → no writes; `err` pulse, `err_code`=01, back in IDLE.
- Header 00 00, checksum 00 → `done` with zero writes. Header 00 02, one byte, then silence → `err` pulse with `err_code`=11 exactly TIMEOUT_CYCLES-1 cycles after the last byte.
- `byte_valid` held high for 5 cycles → exactly one byte counted. `load_en` dropped after 1 of 3 payload bytes → IDLE, no `err`, `busy`=0.
- `rst` asserted during PAYLOAD → all outputs return to reset values next cycle. A following full frame (N=1, 7E, 7E) → `done`.
